// File: rtl/foo_out_capture.sv
// Change-triggered capture of foo's {x, long_out}: each new value is stamped with a cycle count
// and queued in a first-word-fall-through FIFO. Optional FOO_CAPTURE_DROP_CNT_EN adds drop_cnt.
module foo_out_capture #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             x,
  input  logic [128:0]            long_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [63:0]             m_x,
  output logic [128:0]            m_long,
  output logic [SEQ_W-1:0]        m_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    clear_ovf
`ifdef FOO_CAPTURE_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 64 + 129;
  localparam int RW = SEQ_W + SW;

  logic [RW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SW-1:0]    prev_q, prev_d;
  logic             primed_q, primed_d;
  logic             ovf_q, ovf_d;

  logic [SW-1:0]    sample_s;
  logic             change_s;
  logic             full_s;
  logic             pop_s;
  logic             wr_en_s;
  logic             drop_s;

  assign sample_s = {x, long_out};

  // Push/pop/drop decisions; full and empty come from the occupancy count, not pointer equality.
  always_comb begin
    change_s = 1'b0;
    full_s   = 1'b0;
    pop_s    = 1'b0;
    wr_en_s  = 1'b0;
    drop_s   = 1'b0;
    if (rst_n) begin
      change_s = !primed_q || (sample_s != prev_q);
      full_s   = (count_q == CW'(DEPTH));
      pop_s    = (count_q != {CW{1'b0}}) && m_ready;
      wr_en_s  = change_s && (!full_s || pop_s);
      drop_s   = change_s && full_s && !pop_s;
    end else begin
      change_s = 1'b0;
    end
  end

  // Next-state for pointers, occupancy, stamp counter, sample register and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q + SEQ_W'(1);
    prev_d   = sample_s;
    primed_d = 1'b1;
    ovf_d    = ovf_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      seq_q    <= {SEQ_W{1'b0}};
      prev_q   <= {SW{1'b0}};
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {seq_q, sample_s};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

`ifdef FOO_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a clear coinciding with a drop leaves exactly one counted.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf) begin
      drop_cnt_d = drop_s ? 16'd1 : 16'd0;
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign m_valid  = (count_q != {CW{1'b0}});
  assign count    = count_q;
  assign overflow = ovf_q;
  assign m_seq    = mem_q[rd_ptr_q][RW-1:SW];
  assign m_x      = mem_q[rd_ptr_q][SW-1:129];
  assign m_long   = mem_q[rd_ptr_q][128:0];

endmodule

// File: tb/tb_foo_out_capture.sv
// Self-checking bench for foo_out_capture: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then a randomized phase (honours FOO_CAPTURE_DROP_CNT_EN).
module tb_foo_out_capture;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 8;

  typedef struct {
    logic [SEQ_W-1:0] seq;
    logic [63:0]      x;
    logic [128:0]     lng;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      x;
  logic [128:0]     long_out;
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_x;
  logic [128:0]     m_long;
  logic [SEQ_W-1:0] m_seq;
  logic [3:0]       count;
  logic             overflow;
  logic             clear_ovf;
`ifdef FOO_CAPTURE_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  rec_t         mq[$];
  int           m_seqc;
  bit           m_primed;
  logic [192:0] m_prev;
  bit           m_ovf;
  int           m_dcnt;

  foo_out_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .long_out(long_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_long(m_long), .m_seq(m_seq),
    .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
`ifdef FOO_CAPTURE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a record queue updated from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_seqc = 0; m_primed = 1'b0; m_ovf = 1'b0; m_dcnt = 0; m_prev = '0;
    end else begin
      int  sz0;
      bit  pop, chg, drop;
      rec_t r;
      sz0  = mq.size();
      pop  = (sz0 > 0) && m_ready;
      chg  = !m_primed || ({x, long_out} != m_prev);
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (chg) begin
        if (sz0 < DEPTH || pop) begin
          r.seq = SEQ_W'(m_seqc); r.x = x; r.lng = long_out;
          mq.push_back(r);
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      if (clear_ovf) m_dcnt = drop ? 1 : 0;
      else if (drop && m_dcnt < 65535) m_dcnt++;
      m_prev   = {x, long_out};
      m_primed = 1'b1;
      m_seqc   = (m_seqc + 1) % (1 << SEQ_W);
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 256'(m_valid), 256'(mq.size() != 0));
      chk("count", 256'(count), 256'(mq.size()));
      chk("overflow", 256'(overflow), 256'(m_ovf));
`ifdef FOO_CAPTURE_DROP_CNT_EN
      chk("drop_cnt", 256'(drop_cnt), 256'(m_dcnt));
`endif
      if (mq.size() != 0) begin
        chk("m_seq", 256'(m_seq), 256'(mq[0].seq));
        chk("m_x", 256'(m_x), 256'(mq[0].x));
        chk("m_long", 256'(m_long), 256'(mq[0].lng));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [159:0] rnd;
    rst_n = 1'b0; x = 64'd0; long_out = 129'd0; m_ready = 1'b0; clear_ovf = 1'b0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_valid", 256'(m_valid), 256'(1'b0));
    chk("rst_count", 256'(count), 256'(4'd0));
    chk("rst_ovf", 256'(overflow), 256'(1'b0));

    // Constant input: only the priming record appears.
    rst_n = 1'b1; m_ready = 1'b1;
    step();
    chk("prime_count", 256'(count), 256'(4'd1));
    chk("prime_seq", 256'(m_seq), 256'(8'd0));
    chk("prime_x", 256'(m_x), 256'(64'd0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_count", 256'(count), 256'(4'd0));
    end

    // Stepping x from seq 4.
    do_reset(); x = 64'd0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int i = 1; i <= 3; i++) begin
      x = 64'(i);
      step();
      chk("step_valid", 256'(m_valid), 256'(1'b1));
      chk("step_seq", 256'(m_seq), 256'(3 + i));
      chk("step_x", 256'(m_x), 256'(i));
    end
    step();
    chk("step_empty", 256'(m_valid), 256'(1'b0));

    // Overfill: prime + 10 changes into 8 slots.
    do_reset(); x = 64'd0; m_ready = 1'b0;
    step();
    for (int i = 1; i <= 10; i++) begin
      x = 64'(i);
      step();
    end
    chk("full_count", 256'(count), 256'(4'd8));
    chk("full_ovf", 256'(overflow), 256'(1'b1));
    chk("model_size", 256'(mq.size()), 256'(8));
`ifdef FOO_CAPTURE_DROP_CNT_EN
    chk("full_dcnt", 256'(drop_cnt), 256'(16'd3));
`endif
    // Clear coinciding with a drop, then clear alone.
    x = 64'd11; clear_ovf = 1'b1;
    step();
    chk("clr_drop_ovf", 256'(overflow), 256'(1'b1));
`ifdef FOO_CAPTURE_DROP_CNT_EN
    chk("clr_drop_dcnt", 256'(drop_cnt), 256'(16'd1));
`endif
    step();
    chk("clr_ovf", 256'(overflow), 256'(1'b0));
    clear_ovf = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 256'(m_seq), 256'(i));
      chk("drain_x", 256'(m_x), 256'(i));
      step();
    end
    chk("drain_empty", 256'(m_valid), 256'(1'b0));

    // Full with simultaneous push and pop every cycle.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = 64'(100 + i);
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 64'(200 + i);
      step();
      chk("pp_count", 256'(count), 256'(4'd8));
      chk("pp_ovf", 256'(overflow), 256'(1'b0));
    end

    // Mid-stream reset with five queued records.
    do_reset(); m_ready = 1'b0; x = 64'd0;
    for (int i = 0; i < 5; i++) begin
      x = 64'(50 + i);
      step();
    end
    chk("pre_rst_count", 256'(count), 256'(4'd5));
    rst_n = 1'b0;
    step();
    chk("mid_rst_count", 256'(count), 256'(4'd0));
    chk("mid_rst_valid", 256'(m_valid), 256'(1'b0));
    rst_n = 1'b1;
    step();
    chk("post_rst_seq", 256'(m_seq), 256'(8'd0));
    chk("post_rst_valid", 256'(m_valid), 256'(1'b1));
    m_ready = 1'b1;
    step();
    chk("post_rst_pop", 256'(count), 256'(4'd0));
    long_out[128] = ~long_out[128];
    step();
    chk("bit128_valid", 256'(m_valid), 256'(1'b1));
    chk("bit128_long", 256'(m_long[128]), 256'(1'b1));
    chk("bit128_seq", 256'(m_seq), 256'(8'd2));

    // Randomized phase with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 250) % 3;
      rst_n     = ($urandom_range(0, 299) != 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      m_ready   = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                  (ph == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: x[3:0] = 4'($urandom_range(0, 15));
        1: long_out[$urandom_range(0, 128)] = ~long_out[$urandom_range(0, 128)];
        2: begin
          rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
          long_out = rnd[128:0];
          x = {$urandom, $urandom};
        end
        default: x = x;
      endcase
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/foo_out_capture.md
Name: foo_out_capture

Overview:
- Downstream consumer of the foo black-box wrapper.
- Samples foo's outputs x and long_out on every clk and detects when the combined value changes.
- On each change, pushes a timestamped record {seq, x, long_out} into a FIFO, drained through a valid/ready interface.
- Gives the testbench and scoreboard a lossless, cycle-stamped log of foo output transitions, plus overflow reporting.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
SEQ_W, 16, width of cycle-stamp counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
x  input  64  foo output x
long_out  input  129  foo output long_out
m_valid  output  1  record available at head of FIFO
m_ready  input  1  consumer accepts head record
m_x  output  64  head record x
m_long  output  129  head record long_out
m_seq  output  SEQ_W  head record cycle stamp
count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: at least one record dropped
clear_ovf  input  1  clears overflow

Behaviour:
- Reset: sampled when rst_n==0 at a clk edge. Clears FIFO pointers, count=0, m_valid=0, overflow=0, seq=0, and primed=0. Reset mid-operation discards all queued records; m_x/m_long/m_seq are don't-care while m_valid=0.
- seq counter: increments by 1 every clk edge with rst_n==1, wraps modulo 2^SEQ_W. Wrap is silent; consumer handles ordering.
- Sample register prev={x,long_out}: updated every non-reset edge, including when a push is dropped, so a dropped change is never re-pushed.
- Change detect:
  - change = !primed || ({x,long_out} != prev).
  - primed sets on the first non-reset edge, so the first post-reset sample is always recorded.
  - Record pushed carries the current seq value and the current x/long_out.
- FIFO:
  - First-word-fall-through; m_valid = (count != 0); m_* driven from the head entry.
  - Push-to-visibility latency: change sampled at edge N gives m_valid=1 after edge N.
- Pop: occurs when m_valid && m_ready at an edge.
- Boundary cases:
  - Empty with no push: m_valid stays 0; m_ready is ignored.
  - Full, push, no pop: record dropped; overflow set; count stays DEPTH.
  - Full, push and pop in the same cycle: both occur; count stays DEPTH; no drop.
  - Empty, push and m_ready high: no pop this cycle, since m_valid was 0; count becomes 1.
  - Push and pop in any other state: count unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH; full/empty is decided by count, not pointer equality.
- overflow: sticky. clear_ovf clears it at the next edge. If clear_ovf and a drop occur in the same cycle, set wins (overflow=1).
- Record ordering is strictly FIFO; m_seq values of successive records are strictly increasing modulo 2^SEQ_W.

Optional Feature:
- FOO_CAPTURE_DROP_CNT_EN defined:
  - Adds output port drop_cnt[15:0], a saturating count of dropped records (holds at 16'hFFFF).
  - Reset clears it to 0.
  - clear_ovf clears it. If clear_ovf coincides with a drop, drop_cnt becomes 1.
- FOO_CAPTURE_DROP_CNT_EN not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, release; hold x=0, long_out=0 for 5 cycles, m_ready=1 -> exactly one record {seq=0, x=0, long=0}; count returns to 0; no further records.
- m_ready=1; x steps 1,2,3 on consecutive edges starting seq=4 -> records m_seq=4,5,6 with m_x=1,2,3, each m_valid 1 cycle after its sample edge.
- DEPTH=8, m_ready=0, change x on 10 consecutive cycles after prime -> count=8, overflow=1, drop_cnt=3 when enabled. Then m_ready=1 -> 8 records in order: first the prime, then the first 7 changes.
- FIFO full, m_ready=1, change every cycle -> count stays 8, no overflow, continuous m_valid.
- Assert clear_ovf in the same cycle as a drop -> overflow remains 1; clear_ovf alone the next cycle -> overflow=0.
- Mid-stream rst_n=0 for 1 edge with count=5 -> count=0, m_valid=0, overflow=0. Next edge produces a primed record with m_seq=0; long_out bit 128 toggling alone triggers a record.
